// File: rtl/e20_pkg.sv
// E20 ISA shared definitions: opcodes, func codes, field positions, decode helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package e20_pkg;

  localparam int         REG_COUNT = 8;
  localparam logic [2:0] LINK_REG  = 3'd7;

  // Instruction field positions
  localparam int OP_LSB = 13;
  localparam int RA_LSB = 10;
  localparam int RB_LSB = 7;
  localparam int RC_LSB = 4;

  localparam logic [2:0] OP_RRR  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_JEQ  = 3'b110;
  localparam logic [2:0] OP_SLTI = 3'b111;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_OR  = 4'd2;
  localparam logic [3:0] FN_AND = 4'd3;
  localparam logic [3:0] FN_SLT = 4'd4;
  localparam logic [3:0] FN_JR  = 4'd8;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  function automatic logic [2:0] op_of(input logic [15:0] i);
    return i[OP_LSB +: 3];
  endfunction

  function automatic logic [2:0] ra_of(input logic [15:0] i);
    return i[RA_LSB +: 3];
  endfunction

  function automatic logic [2:0] rb_of(input logic [15:0] i);
    return i[RB_LSB +: 3];
  endfunction

  function automatic logic [2:0] rc_of(input logic [15:0] i);
    return i[RC_LSB +: 3];
  endfunction

  function automatic logic [3:0] func_of(input logic [15:0] i);
    return i[3:0];
  endfunction

  function automatic logic [15:0] sext7(input logic [15:0] i);
    return {{9{i[6]}}, i[6:0]};
  endfunction

  // Destination register; 0 means "no write" (writes to $0 are discarded anyway)
  function automatic logic [2:0] dst_of(input logic [15:0] i);
    logic [2:0] d;
    d = 3'd0;
    case (op_of(i))
      OP_RRR:                  if (func_of(i) <= FN_SLT) d = rc_of(i);
      OP_ADDI, OP_LW, OP_SLTI: d = rb_of(i);
      OP_JAL:                  d = LINK_REG;
      default:                 d = 3'd0;
    endcase
    return d;
  endfunction

  function automatic logic reads_a(input logic [15:0] i);
    return (op_of(i) != OP_J) && (op_of(i) != OP_JAL);
  endfunction

  function automatic logic reads_b(input logic [15:0] i);
    return (op_of(i) == OP_RRR) || (op_of(i) == OP_SW) || (op_of(i) == OP_JEQ);
  endfunction

endpackage

// File: rtl/e20_hazard_unit.sv
// Hazard control: EX operand forwarding selects, load-use stall, control-transfer flush.
// Latency: purely combinational.
// Backpressure: stall holds IF/ID and bubbles EX; flush kills IF and ID.
// Ports: id_* = instruction in ID; ex_*/mem_*/wb_* = stage valid/dest info; outputs fwd_a/fwd_b/stall/flush.
module e20_hazard_unit
  import e20_pkg::*;
(
  input  logic        id_vld,
  input  logic [15:0] id_instr,
  input  logic        ex_vld,
  input  logic        ex_lw,
  input  logic [2:0]  ex_dst,
  input  logic [2:0]  ex_ra,
  input  logic [2:0]  ex_rb,
  input  logic        ex_taken,
  input  logic        mem_vld,
  input  logic        mem_lw,
  input  logic [2:0]  mem_dst,
  input  logic        wb_vld,
  input  logic [2:0]  wb_dst,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic        flush
);

  // A load in MEM has no data yet; the load-use stall guarantees no consumer needs it there.
  logic mem_fwd_ok;
  logic wb_fwd_ok;
  assign mem_fwd_ok = mem_vld && !mem_lw && (mem_dst != 3'd0);
  assign wb_fwd_ok  = wb_vld && (wb_dst != 3'd0);

  always_comb begin
    fwd_a = FWD_REG;
    if (mem_fwd_ok && mem_dst == ex_ra)     fwd_a = FWD_MEM;
    else if (wb_fwd_ok && wb_dst == ex_ra)  fwd_a = FWD_WB;
  end

  always_comb begin
    fwd_b = FWD_REG;
    if (mem_fwd_ok && mem_dst == ex_rb)     fwd_b = FWD_MEM;
    else if (wb_fwd_ok && wb_dst == ex_rb)  fwd_b = FWD_WB;
  end

  always_comb begin
    stall = 1'b0;
    if (ex_vld && ex_lw && (ex_dst != 3'd0) && id_vld) begin
      stall = (reads_a(id_instr) && ra_of(id_instr) == ex_dst) ||
              (reads_b(id_instr) && rb_of(id_instr) == ex_dst);
    end
  end

  assign flush = ex_taken;

endmodule

// File: rtl/processor_pipelined.sv
// 5-stage (IF/ID/EX/MEM/WB) E20 core with unified word-addressed memory and halt detection.
// Latency: 5-cycle fill; load-use costs 1 stall, taken control transfers cost 2 flushed slots.
// Backpressure: none external; halts (all state frozen) after a self-targeting jump retires.
// Ports: clock, reset (async active-low), halt, debug_pc/debug_instr (IF stage), debug_cycle.
module processor_pipelined
  import e20_pkg::*;
#(
  parameter int MEM_DEPTH = 8192,
  parameter int PC_WIDTH  = 16
) (
  input  logic                clock,
  input  logic                reset,
  output logic                halt,
  output logic [PC_WIDTH-1:0] debug_pc,
  output logic [15:0]         debug_instr,
  output logic [31:0]         debug_cycle
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [15:0] ram  [0:MEM_DEPTH-1];
  logic [15:0] regs [0:REG_COUNT-1];

  logic [PC_WIDTH-1:0] pc;
  logic                halting;   // halt detected in EX: fetch stopped, waiting for WB

  logic                id_vld;
  logic [PC_WIDTH-1:0] id_pc;
  logic [15:0]         id_instr;

  logic                ex_vld;
  logic [PC_WIDTH-1:0] ex_pc;
  logic [15:0]         ex_instr, ex_a_reg, ex_b_reg;

  logic                mem_vld, mem_lw, mem_sw, mem_halt;
  logic [2:0]          mem_dst;
  logic [15:0]         mem_res, mem_sdat;

  logic                wb_vld, wb_halt;
  logic [2:0]          wb_dst;
  logic [15:0]         wb_val;

  assign debug_pc    = pc;
  assign debug_instr = ram[pc[AW-1:0]];

  // ID: register read, with WB bypass so the file behaves write-before-read
  logic [2:0]  id_ra, id_rb;
  logic [15:0] id_a_val, id_b_val;
  assign id_ra    = ra_of(id_instr);
  assign id_rb    = rb_of(id_instr);
  assign id_a_val = (wb_vld && wb_dst != 3'd0 && wb_dst == id_ra) ? wb_val : regs[id_ra];
  assign id_b_val = (wb_vld && wb_dst != 3'd0 && wb_dst == id_rb) ? wb_val : regs[id_rb];

  // Hazard unit
  logic [1:0] fwd_a, fwd_b;
  logic       stall, flush;
  logic       ex_taken_raw, ex_taken, ex_halt, ex_lw;
  logic [2:0] ex_dst;

  assign ex_lw  = (op_of(ex_instr) == OP_LW);
  assign ex_dst = dst_of(ex_instr);

  e20_hazard_unit u_hazard (
    .id_vld   (id_vld),
    .id_instr (id_instr),
    .ex_vld   (ex_vld),
    .ex_lw    (ex_lw),
    .ex_dst   (ex_dst),
    .ex_ra    (ra_of(ex_instr)),
    .ex_rb    (rb_of(ex_instr)),
    .ex_taken (ex_taken),
    .mem_vld  (mem_vld),
    .mem_lw   (mem_lw),
    .mem_dst  (mem_dst),
    .wb_vld   (wb_vld),
    .wb_dst   (wb_dst),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b),
    .stall    (stall),
    .flush    (flush)
  );

  // EX: operand forwarding and execute
  logic [15:0]         a_val, b_val, imm, ex_res;
  logic [PC_WIDTH-1:0] ex_target, pc_inc;

  always_comb begin
    case (fwd_a)
      FWD_MEM: a_val = mem_res;
      FWD_WB:  a_val = wb_val;
      default: a_val = ex_a_reg;
    endcase
    case (fwd_b)
      FWD_MEM: b_val = mem_res;
      FWD_WB:  b_val = wb_val;
      default: b_val = ex_b_reg;
    endcase
  end

  assign pc_inc = ex_pc + PC_WIDTH'(1);

  always_comb begin
    imm          = sext7(ex_instr);
    ex_res       = 16'd0;
    ex_taken_raw = 1'b0;
    ex_target    = pc_inc;
    case (op_of(ex_instr))
      OP_RRR: begin
        case (func_of(ex_instr))
          FN_ADD:  ex_res = a_val + b_val;
          FN_SUB:  ex_res = a_val - b_val;
          FN_OR:   ex_res = a_val | b_val;
          FN_AND:  ex_res = a_val & b_val;
          FN_SLT:  ex_res = {15'd0, a_val < b_val};
          FN_JR: begin
            ex_taken_raw = 1'b1;
            ex_target    = PC_WIDTH'(a_val);
          end
          default: ex_res = 16'd0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: ex_res = a_val + imm;
      OP_J: begin
        ex_taken_raw = 1'b1;
        ex_target    = PC_WIDTH'(ex_instr[12:0]);
      end
      OP_JAL: begin
        ex_taken_raw = 1'b1;
        ex_target    = PC_WIDTH'(ex_instr[12:0]);
        ex_res       = 16'(pc_inc);
      end
      OP_JEQ: begin
        if (a_val == b_val) begin
          ex_taken_raw = 1'b1;
          ex_target    = pc_inc + PC_WIDTH'(imm);
        end
      end
      default: ex_res = {15'd0, a_val < imm};  // slti
    endcase
  end

  assign ex_taken = ex_vld && ex_taken_raw;
  assign ex_halt  = ex_taken && (ex_target == ex_pc);

  // MEM: combinational read port 2
  logic [15:0] wb_next;
  assign wb_next = mem_lw ? ram[mem_res[AW-1:0]] : mem_res;

  // Pipeline state; everything freezes once halt is set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      halting     <= 1'b0;
      halt        <= 1'b0;
      debug_cycle <= 32'd0;
      id_vld      <= 1'b0;
      id_pc       <= '0;
      id_instr    <= 16'd0;
      ex_vld      <= 1'b0;
      ex_pc       <= '0;
      ex_instr    <= 16'd0;
      ex_a_reg    <= 16'd0;
      ex_b_reg    <= 16'd0;
      mem_vld     <= 1'b0;
      mem_lw      <= 1'b0;
      mem_sw      <= 1'b0;
      mem_halt    <= 1'b0;
      mem_dst     <= 3'd0;
      mem_res     <= 16'd0;
      mem_sdat    <= 16'd0;
      wb_vld      <= 1'b0;
      wb_halt     <= 1'b0;
      wb_dst      <= 3'd0;
      wb_val      <= 16'd0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 16'd0;
    end else if (!halt) begin
      debug_cycle <= debug_cycle + 32'd1;

      // IF -> ID
      if (flush) begin
        pc     <= ex_target;
        id_vld <= 1'b0;
        if (ex_halt) halting <= 1'b1;
      end else if (halting) begin
        id_vld <= 1'b0;
      end else if (!stall) begin
        pc       <= pc + PC_WIDTH'(1);
        id_vld   <= 1'b1;
        id_pc    <= pc;
        id_instr <= ram[pc[AW-1:0]];
      end

      // ID -> EX
      if (flush || stall) begin
        ex_vld <= 1'b0;
      end else begin
        ex_vld   <= id_vld;
        ex_pc    <= id_pc;
        ex_instr <= id_instr;
        ex_a_reg <= id_a_val;
        ex_b_reg <= id_b_val;
      end

      // EX -> MEM
      mem_vld  <= ex_vld;
      mem_lw   <= ex_lw;
      mem_sw   <= (op_of(ex_instr) == OP_SW);
      mem_dst  <= ex_dst;
      mem_res  <= ex_res;
      mem_sdat <= b_val;
      mem_halt <= ex_halt;

      // MEM -> WB
      wb_vld  <= mem_vld;
      wb_dst  <= mem_dst;
      wb_val  <= wb_next;
      wb_halt <= mem_halt;

      // WB
      if (wb_vld && wb_dst != 3'd0) regs[wb_dst] <= wb_val;
      if (wb_vld && wb_halt)        halt <= 1'b1;
    end
  end

  // Port 2 write; a same-cycle fetch of this address still sees the old word
  always_ff @(posedge clock) begin
    if (reset && !halt && mem_vld && mem_sw) ram[mem_res[AW-1:0]] <= mem_sdat;
  end

endmodule

// File: tb/tb_processor_pipelined.sv
// Directed program bench for processor_pipelined with an end-of-program scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_processor_pipelined;

  logic        clock;
  logic        reset;
  logic        halt;
  logic [15:0] debug_pc;
  logic [15:0] debug_instr;
  logic [31:0] debug_cycle;

  processor_pipelined dut (
    .clock       (clock),
    .reset       (reset),
    .halt        (halt),
    .debug_pc    (debug_pc),
    .debug_instr (debug_instr),
    .debug_cycle (debug_cycle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // kind: 0 = register, 1 = ram word, 2 = debug_pc, 3 = debug_cycle
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] idx;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] prog_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int idx, input logic [31:0] exp);
    sb_q.push_back('{kind, idx[15:0], exp});
  endtask

  // Hold reset, load the program, release on a falling edge
  task automatic start_prog();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) dut.ram[i] = 16'h0000;
    for (int i = 0; i < prog_q.size(); i++) dut.ram[i] = prog_q[i];
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Wait (bounded) for halt, idle a few cycles to show the state is frozen, then drain the scoreboard
  task automatic finish_prog(input string name, output logic [31:0] cyc);
    int          n;
    sb_t         e;
    logic [31:0] obs;
    n = 0;
    while (halt !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_halt"}, {31'd0, halt}, 32'd1);
    repeat (4) @(negedge clock);
    cyc = debug_cycle;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        2'd0:    obs = {16'd0, dut.regs[e.idx[2:0]]};
        2'd1:    obs = {16'd0, dut.ram[e.idx[12:0]]};
        2'd2:    obs = {16'd0, debug_pc};
        default: obs = debug_cycle;
      endcase
      chk($sformatf("%s_k%0d_%0d", name, e.kind, e.idx), obs, e.exp);
    end
  endtask

  logic [31:0] cyc, cyc_dep, cyc_nodep;

  initial begin
    // Asynchronous reset takes effect between clock edges
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_halt",  {31'd0, halt}, 32'd0);
    chk("rst_cycle", debug_cycle, 32'd0);
    chk("rst_pc",    {16'd0, debug_pc}, 32'd0);
    chk("rst_reg1",  {16'd0, dut.regs[1]}, 32'd0);

    // Basic: addi, addi, j 2 (halt)
    prog_q = '{16'h2085, 16'h2103, 16'h4002};
    push(0, 1, 5);
    push(0, 2, 3);
    for (int r = 3; r < 8; r++) push(0, r, 0);
    push(2, 0, 2);
    push(3, 0, 7);
    start_prog();
    finish_prog("basic", cyc);

    // Forwarding: addi $1,7; add $2,$1,$1; sub $3,$2,$1; j 3
    prog_q = '{16'h2087, 16'h04A0, 16'h08B1, 16'h4003};
    push(0, 1, 7);
    push(0, 2, 14);
    push(0, 3, 7);
    push(2, 0, 3);
    start_prog();
    finish_prog("fwd", cyc);

    // Load-use: addi $1,50; lw $2,50($1); add $3,$2,$2; j 3
    dut.ram[100] = 16'h1234;
    prog_q = '{16'h20B2, 16'h8532, 16'h0930, 16'h4003};
    push(0, 1, 50);
    push(0, 2, 16'h1234);
    push(0, 3, 16'h2468);
    start_prog();
    finish_prog("ldu", cyc_dep);
    chk("ldu_cycles", cyc_dep, 32'd9);

    // Same program, add uses $1 instead: no stall
    prog_q = '{16'h20B2, 16'h8532, 16'h04B0, 16'h4003};
    push(0, 2, 16'h1234);
    push(0, 3, 100);
    start_prog();
    finish_prog("nodep", cyc_nodep);
    chk("nodep_cycles", cyc_nodep, 32'd8);
    chk("stall_delta", cyc_dep - cyc_nodep, 32'd1);

    // Branches: jeq taken over addi $4; jal 5; addi $5; j 4; addi $6; jr $7; two shadow addis
    prog_q = '{16'hC001, 16'h2201, 16'h6005, 16'h2289, 16'h4004,
               16'h2302, 16'h1C08, 16'h2081, 16'h2101};
    push(0, 4, 0);
    push(0, 7, 3);
    push(0, 5, 9);
    push(0, 6, 2);
    push(0, 1, 0);
    push(0, 2, 0);
    push(2, 0, 4);
    start_prog();
    finish_prog("br", cyc);

    // Store/load and $0: addi $1,0x21; sw $1,10($0); lw $2,10($0); addi $0,$1,5; add $3,$0,$2; j 5
    prog_q = '{16'h20A1, 16'hA08A, 16'h810A, 16'h2405, 16'h0130, 16'h4005};
    push(0, 0, 0);
    push(0, 2, 16'h21);
    push(0, 3, 16'h21);
    push(1, 10, 16'h21);
    push(2, 0, 5);
    start_prog();
    finish_prog("swlw", cyc);

    // Mid-program reset pulse: state clears, ram survives, program reruns from 0
    prog_q = '{16'h2087, 16'h04A0, 16'h08B1, 16'h4003};
    start_prog();
    repeat (6) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_halt",  {31'd0, halt}, 32'd0);
    chk("mid_rst_cycle", debug_cycle, 32'd0);
    chk("mid_rst_pc",    {16'd0, debug_pc}, 32'd0);
    chk("mid_rst_reg1",  {16'd0, dut.regs[1]}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    push(0, 1, 7);
    push(0, 2, 14);
    push(0, 3, 7);
    push(1, 100, 16'h1234);
    push(1, 0, 16'h2087);
    push(3, 0, 8);
    finish_prog("rerun", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/processor_pipelined.md
Name: processor_pipelined

Overview:
- 5-stage pipelined (IF/ID/EX/MEM/WB) implementation of the 16-bit E20 ISA.
- Eight 16-bit registers and one unified 8192×16 word-addressed memory for instructions and data.
- Runs from address 0 after reset until a self-targeting control transfer, then asserts halt.
- Top-level core of the modified RISC processor; debug outputs feed benches and trace logs.

Parameters:
- MEM_DEPTH, 8192, memory words; addresses are PC/effective address modulo MEM_DEPTH (13 bits).
- PC_WIDTH, 16, program counter width.

Ports:
- clock, input, 1, sole clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-low (0 = reset asserted).
- halt, output, 1, sticky high once the halting instruction retires.
- debug_pc, output, 16, PC of the instruction in IF; holds the halting instruction's PC after halt.
- debug_instr, output, 16, instruction word fetched in IF this cycle.
- debug_cycle, output, 32, cycles since reset release; frozen at halt.

Behaviour:
- Storage arrays must be named ram[0:MEM_DEPTH-1] (16-bit) and regs[0:7] (16-bit); benches preload and inspect them hierarchically.
- Reset is asserted by reset=0, taking effect asynchronously:
  - PC=0, all pipeline valid bits=0, regs all 0, halt=0, debug_cycle=0.
  - ram is not cleared by reset.
- regs[0] always reads 0; writes to it are discarded.
- Encoding: op=[15:13]; A=[12:10]; B=[9:7]; C=[6:4]; imm7=[6:0], sign-extended; imm13=[12:0].
- op 000 (three-register, dst=C), selected by func [3:0]:
  - 0 add: C=A+B.
  - 1 sub: C=A−B.
  - 2 or: C=A|B.
  - 3 and: C=A&B.
  - 4 slt: C=(A<B) unsigned.
  - 8 jr: pc=A.
  - Other func values execute as NOP.
- op 001 addi: B=A+imm7.
- op 010 j: pc=imm13.
- op 011 jal: $7=pc+1, then pc=imm13.
- op 100 lw: B=ram[(A+imm7) mod 8192].
- op 101 sw: ram[(A+imm7) mod 8192]=B.
- op 110 jeq: if A==B, pc=pc+1+imm7.
- op 111 slti: B=(A < sext(imm7)), unsigned compare.
- Arithmetic is 16-bit and wraps with no flags; PC increments modulo 2^16.
- Memory ports:
  - Port 1: IF read.
  - Port 2: MEM read/write.
  - Both are combinational-read, synchronous-write.
  - A sw to an address being fetched the same cycle: the fetch returns the old word.
- Forwarding:
  - EX operands forward from EX/MEM, then MEM/WB, then the register file.
  - The register file is write-before-read in the same cycle.
- Load-use hazard (lw result consumed by the next instruction): stall IF/ID 1 cycle and insert a bubble into EX.
- Control transfers (j, jal, jr, taken jeq) resolve in EX: flush IF and ID (2-cycle penalty); not-taken jeq costs nothing.
- Halt condition: a control transfer in EX whose target equals its own PC.
  - On detection: stop fetching and flush younger instructions.
  - Older instructions complete normally.
  - When the halting instruction reaches WB, halt=1 and all state freezes: no reg/ram writes, debug_cycle stops, PC stops.
- Halt is released only by reset.
- An asynchronous reset in mid-execution aborts all in-flight instructions; no partial writes complete.

Decomposition:
- Shared package e20_pkg: opcode constants, func codes, field bit positions, REG_COUNT=8, LINK_REG=7.
- Natural sub-module: e20_hazard_unit (forwarding selects, load-use stall, flush control).
- Datapath and storage stay in processor_pipelined.

Test Plan:
- addi $1,$0,5 (0x2085); addi $2,$0,3 (0x2103); j 2 (0x4002) → halt=1, regs[1]=5, regs[2]=3, debug_pc=2, others 0.
- Back-to-back dependency: addi $1,$0,7; add $2,$1,$1; sub $3,$2,$1; then a self-jump → regs[2]=14, regs[3]=7, proving EX/MEM and MEM/WB forwarding.
- Load-use: ram[100]=0x1234; addi $1,$0,50; lw $2,50($1); add $3,$2,$2; then a self-jump → regs[3]=0x2468; exactly one stall cycle versus the non-dependent variant.
- Branches:
  - jeq taken over one addi → the skipped register stays 0.
  - jal → regs[7]=return PC.
  - jr $7 → execution returns there.
  - The 2 flushed instructions leave no side effects.
- sw then lw to the same address, plus a write to $0 → regs[0] remains 0; lw returns the stored value.
- Reset pulse (reset=0 for 2 cycles) mid-program → halt=0, debug_cycle=0, and execution restarts from PC 0 with ram preserved.
